// File: rtl/line_burst_pkg.sv
// rtl/line_burst_pkg.sv - shared types and sizes for the line/burst adapter
package line_burst_pkg;

    // Default geometry: one 256-bit cacheline moved as four 64-bit memory beats.
    localparam int S_LINE  = 256;
    localparam int S_BURST = 64;
    localparam int NBEAT   = S_LINE / S_BURST;

    // Adapter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : line_burst_pkg

// File: rtl/line_burst_adapter.sv
// rtl/line_burst_adapter.sv - converts cacheline requests into 4-beat memory bursts
module line_burst_adapter #(
    parameter int S_LINE  = line_burst_pkg::S_LINE,
    parameter int S_BURST = line_burst_pkg::S_BURST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [S_LINE-1:0]   line_i,
    output logic [S_LINE-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [S_BURST-1:0]  burst_i,
    output logic [S_BURST-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    import line_burst_pkg::*;

    localparam int N_BEAT = S_LINE / S_BURST;
    localparam int CNT_W  = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
    localparam int OFF_W  = $clog2(S_LINE / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEAT - 1);

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:OFF_W]     addr_q;
    // Holds the writeback line during WRITE and the partially assembled fill during READ.
    logic [S_LINE-1:0]   line_buf;
    logic [S_LINE-1:0]   assembled;
    logic                last_beat;

    assign last_beat = resp_i && (cnt_q == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; write wins over read when both are requested.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WRITE;
                end else if (read_i) begin
                    state_d = READ;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill buffer with the current beat merged into its slot.
    always_comb begin
        assembled = line_buf;
        assembled[int'(cnt_q) * S_BURST +: S_BURST] = burst_i;
    end

    // Request latch, beat counter, assembly buffer and the published fill line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            line_buf <= '0;
            line_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (write_i) begin
                        addr_q   <= address_i[31:OFF_W];
                        line_buf <= line_i;
                    end else if (read_i) begin
                        addr_q <= address_i[31:OFF_W];
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_buf <= assembled;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        // line_o only changes once the whole line is in.
                        if (cnt_q == LAST_BEAT) begin
                            line_o <= assembled;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    // Memory-side outputs decode directly from state and counter.
    always_comb begin
        address_o = {addr_q, {OFF_W{1'b0}}};
        read_o    = (state_q == READ);
        write_o   = (state_q == WRITE);
        resp_o    = (state_q == DONE);
        burst_o   = line_buf[int'(cnt_q) * S_BURST +: S_BURST];
    end

endmodule : line_burst_adapter

// File: tb/tb_line_burst_adapter.sv
// tb/tb_line_burst_adapter.sv - directed self-checking bench for line_burst_adapter
module tb_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks;
    int failures;

    logic [63:0]  beat [4];
    logic [255:0] exp_line;

    line_burst_adapter #(.S_LINE(256), .S_BURST(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back beats from beat[]; resp_o must stay low until after the last.
    task automatic send_beats(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_resp_low"}, resp_o, 1'b0);
            burst_i = beat[i];
            resp_i  = 1'b1;
            step();
        end
        resp_i  = 1'b0;
        burst_i = 64'hdead_dead_dead_dead;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_read_o",  read_o,  1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o",  resp_o,  1'b0);
        check("rst_line_o",  line_o,  256'h0);
        check("rst_addr_o",  address_o, 32'h0);
        check("rst_burst_o", burst_o, 64'h0);
        rst = 1'b1;
        step();

        // Basic read, back-to-back beats, 6-cycle latency
        beat[0] = 64'h1111_1111_1111_1111;
        beat[1] = 64'h2222_2222_2222_2222;
        beat[2] = 64'h3333_3333_3333_3333;
        beat[3] = 64'h4444_4444_4444_4444;
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        step();
        read_i    = 1'b0;
        address_i = 32'hffff_ffff;
        check("rd_read_o", read_o, 1'b1);
        check("rd_addr_o", address_o, 32'h0000_1220);
        send_beats("rd");
        check("rd_resp_o",    resp_o, 1'b1);
        check("rd_read_drop", read_o, 1'b0);
        check("rd_addr_hold", address_o, 32'h0000_1220);
        check("rd_line_o",    line_o, {beat[3], beat[2], beat[1], beat[0]});
        step();
        check("rd_resp_once", resp_o, 1'b0);
        exp_line = {beat[3], beat[2], beat[1], beat[0]};

        // Write with a gap before the first beat
        line_i    = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        address_i = 32'h0000_a0ff;
        write_i   = 1'b1;
        step();
        write_i   = 1'b0;
        line_i    = '0;
        check("wr_write_o", write_o, 1'b1);
        check("wr_addr_o",  address_o, 32'h0000_a0e0);
        check("wr_gap_beat0", burst_o, 64'h8796a5b4c3d2e1f0);
        step();
        check("wr_beat0", burst_o, 64'h8796a5b4c3d2e1f0);
        resp_i = 1'b1;
        step();
        check("wr_beat1", burst_o, 64'h0f1e2d3c4b5a6978);
        step();
        check("wr_beat2", burst_o, 64'hfedcba9876543210);
        step();
        check("wr_beat3", burst_o, 64'h0123456789abcdef);
        check("wr_write_hold", write_o, 1'b1);
        step();
        resp_i = 1'b0;
        check("wr_write_drop", write_o, 1'b0);
        check("wr_resp_o", resp_o, 1'b1);
        check("wr_line_o_kept", line_o, exp_line);
        step();
        check("wr_resp_once", resp_o, 1'b0);

        // Read with gapped acknowledge pattern 1,0,0,1,1,0,1
        address_i = 32'h8000_0040;
        read_i    = 1'b1;
        step();
        read_i = 1'b0;
        begin
            logic [6:0]  pat;
            logic [63:0] vals [7];
            pat = 7'b1011001; // bit 0 first
            for (int i = 0; i < 7; i++) vals[i] = {32'hcafe_0000, 32'(i)};
            for (int i = 0; i < 7; i++) begin
                check("gap_resp_low", resp_o, 1'b0);
                burst_i = vals[i];
                resp_i  = pat[i];
                step();
            end
            resp_i = 1'b0;
            check("gap_resp_o", resp_o, 1'b1);
            check("gap_line_o", line_o, {vals[6], vals[4], vals[3], vals[0]});
        end
        step();

        // Read and write together: write wins
        beat[0] = 64'h0; beat[1] = 64'h0; beat[2] = 64'h0; beat[3] = 64'h0;
        line_i  = 256'h5;
        read_i  = 1'b1;
        write_i = 1'b1;
        step();
        read_i  = 1'b0;
        write_i = 1'b0;
        check("both_write_o", write_o, 1'b1);
        check("both_read_o",  read_o,  1'b0);
        send_beats("both");
        check("both_resp_o", resp_o, 1'b1);
        step();

        // Reset mid-burst after two beats
        address_i = 32'h0000_3000;
        read_i    = 1'b1;
        step();
        read_i  = 1'b0;
        resp_i  = 1'b1;
        burst_i = 64'haaaa_aaaa_aaaa_aaaa;
        step();
        step();
        resp_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_read_o", read_o, 1'b0);
        check("mid_rst_resp_o", resp_o, 1'b0);
        check("mid_rst_line_o", line_o, 256'h0);
        check("mid_rst_addr_o", address_o, 32'h0);
        check("mid_rst_burst_o", burst_o, 64'h0);
        step();
        rst = 1'b1;
        step();
        beat[0] = 64'h0101_0101_0101_0101;
        beat[1] = 64'h0202_0202_0202_0202;
        beat[2] = 64'h0303_0303_0303_0303;
        beat[3] = 64'h0404_0404_0404_0404;
        address_i = 32'h0000_5678;
        read_i    = 1'b1;
        step();
        read_i = 1'b0;
        check("post_rst_addr_o", address_o, 32'h0000_5660);
        send_beats("post_rst");
        check("post_rst_resp_o", resp_o, 1'b1);
        check("post_rst_line_o", line_o, {beat[3], beat[2], beat[1], beat[0]});
        step();

        // read_i held through DONE; stray resp_i in DONE and IDLE ignored
        beat[0] = 64'h9000_0000_0000_0001;
        beat[1] = 64'h9000_0000_0000_0002;
        beat[2] = 64'h9000_0000_0000_0003;
        beat[3] = 64'h9000_0000_0000_0004;
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        step();
        send_beats("hold1");
        check("hold_done_resp", resp_o, 1'b1);
        check("hold_done_read_o", read_o, 1'b0);
        resp_i  = 1'b1;
        burst_i = 64'hbad0_bad0_bad0_bad0;
        step();
        check("hold_idle_resp", resp_o, 1'b0);
        check("hold_idle_read_o", read_o, 1'b0);
        step();
        resp_i = 1'b0;
        read_i = 1'b0;
        check("hold_second_read_o", read_o, 1'b1);
        check("hold_line_kept", line_o, {beat[3], beat[2], beat[1], beat[0]});
        beat[0] = 64'h7000_0000_0000_0001;
        beat[1] = 64'h7000_0000_0000_0002;
        beat[2] = 64'h7000_0000_0000_0003;
        beat[3] = 64'h7000_0000_0000_0004;
        send_beats("hold2");
        check("hold2_resp_o", resp_o, 1'b1);
        check("hold2_line_o", line_o, {beat[3], beat[2], beat[1], beat[0]});
        step();
        check("hold2_resp_once", resp_o, 1'b0);
        check("hold2_idle_read_o", read_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_line_burst_adapter

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 SHALL have parameter S_LINE, default 256, cacheline width in bits.
REQ-002 SHALL have parameter S_BURST, default 64, memory beat width in bits; beats per line NBEAT = S_LINE/S_BURST = 4.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port line_i  input  S_LINE  writeback line from the cache (pmem_wdata).
REQ-006 SHALL have port line_o  output  S_LINE  fill line to the cache (pmem_rdata).
REQ-007 SHALL have port address_i  input  32  line request address from the cache (pmem_address).
REQ-008 SHALL have ports read_i and write_i, each input 1, the line read and line write requests from the cache.
REQ-009 SHALL have port resp_o  output  1  line transfer complete, to the cache (pmem_resp).
REQ-010 SHALL have port burst_i  input  S_BURST  read beat from memory.
REQ-011 SHALL have port burst_o  output  S_BURST  write beat to memory.
REQ-012 SHALL have port address_o  output  32  burst address to memory, line-aligned.
REQ-013 SHALL have ports read_o and write_o, each output 1, the burst read and burst write requests to memory.
REQ-014 SHALL have port resp_i  input  1  memory beat acknowledge; one beat is transferred per cycle in which it is high.

Function
REQ-015 SHALL implement an FSM with states IDLE, READ, WRITE and DONE.
REQ-016 In IDLE, write_i=1 SHALL latch line_i and address_i and enter WRITE; write has priority when read_i=1 and write_i=1 together.
REQ-017 In IDLE, read_i=1 with write_i=0 SHALL latch address_i and enter READ.
REQ-018 address_o SHALL be {latched address[31:5], 5'b0} and SHALL stay stable for the whole burst.
REQ-019 read_o SHALL be high exactly while in READ; write_o SHALL be high exactly while in WRITE.
REQ-020 A 2-bit beat counter SHALL reset to 0 on entering READ or WRITE and SHALL increment only on cycles with resp_i=1; gaps in resp_i SHALL be tolerated.
REQ-021 In READ, each resp_i=1 cycle SHALL store burst_i into line bits [64*cnt+63 : 64*cnt], beat 0 being the least significant.
REQ-022 In WRITE, burst_o SHALL present latched line bits [64*cnt+63 : 64*cnt] combinationally from the counter.
REQ-023 On the resp_i cycle with cnt=3, the FSM SHALL move to DONE; resp_i seen in DONE is ignored.
REQ-024 In DONE, resp_o SHALL be high for exactly one cycle, line_o SHALL hold the assembled line, and the FSM SHALL return to IDLE.
REQ-025 line_o SHALL keep the last filled line until the next read completes.
REQ-026 A new request SHALL be accepted no earlier than IDLE after DONE; requests held through DONE SHALL be ignored there.
REQ-027 resp_i in IDLE SHALL be ignored.
REQ-028 With back-to-back resp_i, the minimum latency SHALL be 6 cycles from the request edge to resp_o: 1 to enter READ/WRITE, 4 beats, then 1 cycle in DONE.

Reset
REQ-029 rst=0 SHALL force, at any time, including mid-burst: state IDLE, counter 0, read_o=0, write_o=0, resp_o=0, line_o=0, and the latched address and write line to 0.
REQ-030 After rst deasserts, the first request SHALL behave as if no prior burst had occurred.

Structure
REQ-031 The state enum, S_LINE, S_BURST and NBEAT SHALL live in a shared package, line_burst_pkg.
REQ-032 The design SHALL be a single module with no sub-module; counter, FSM and line register SHALL stay inline.

Verification
REQ-033 Read, address_i=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. on consecutive resp_i -> address_o=0x0000_1220, resp_o on the 6th cycle, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-034 Write, line_i=256'h0123...CDEF -> burst_o shows bits [63:0], [127:64], [191:128], [255:192] in order, write_o drops after beat 3, resp_o pulses once.
REQ-035 Read with resp_i pattern 1,0,0,1,1,0,1 -> four beats captured correctly and resp_o one cycle after the last beat.
REQ-036 read_i=1 and write_i=1 together in IDLE -> write_o=1, read_o=0.
REQ-037 rst pulsed low after 2 read beats -> all outputs 0 at once; a subsequent full read completes with correct data.
REQ-038 read_i held high through DONE -> exactly one resp_o per accepted request, and a second burst starts only from IDLE.
